// File: rtl/acc.sv
// acc: WIDTH-bit accumulator register for the calculator datapath.
// Loads `in` on a rising CLK when `w` is high and holds it otherwise.
// `out` is driven straight from the register, so there is no
// combinational path from `in` or `w`. RESET clears the register
// asynchronously and holds it cleared while RESET stays high.
module acc #(
   parameter int unsigned           WIDTH       = 16,
   parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             w,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] out
);

   logic [WIDTH-1:0] value_q;

   // Storage register: async clear, otherwise load on write enable.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         value_q <= RESET_VALUE;
      end else if (w) begin
         // NOTE: non-blocking assignment so every reader of value_q in this
         // timestep sees the pre-edge value; blocking would create races.
         value_q <= in;
      end
   end

   assign out = value_q;

endmodule

// File: tb/tb_acc.sv
// tb_acc: directed, table-driven bench for the acc register.
// Inputs change on the falling edge; outputs are sampled 1 time unit
// after the falling edge (pre-edge value) and 1 unit after the rising
// edge (post-edge value). Reset-mid-cycle and between-edge input
// changes are covered by a hand-written sequence.
`timescale 1ns/1ps
module tb_acc;

   localparam int W = 16;

   logic         CLK;
   logic         RESET;
   logic         w;
   logic [W-1:0] in;
   logic [W-1:0] out;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic         rst;
      logic         wr;
      logic [W-1:0] din;
      logic [W-1:0] exp_before;  // out just after driving, before the edge
      logic [W-1:0] exp_after;   // out just after the rising edge
   } vec_t;

   vec_t vecs_a[7];
   vec_t vecs_b[5];

   acc #(.WIDTH(W), .RESET_VALUE('0)) dut (
      .CLK  (CLK),
      .RESET(RESET),
      .w    (w),
      .in   (in),
      .out  (out)
   );

   // 10 ns clock, rising edges at 5, 15, 25, ...
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic check(input string name, input logic [W-1:0] act,
                        input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: out=0x%04h expected 0x%04h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic apply(input vec_t v, input string tag, input int idx);
      @(negedge CLK);
      RESET = v.rst;
      w     = v.wr;
      in    = v.din;
      #1;
      check($sformatf("%s[%0d].before", tag, idx), out, v.exp_before);
      @(posedge CLK);
      #1;
      check($sformatf("%s[%0d].after", tag, idx), out, v.exp_after);
   endtask

   initial begin
      // Power-up under reset, then first write, then holds, then a new write.
      vecs_a[0] = '{1'b1, 1'b1, 16'h6AB3, 16'h0000, 16'h0000};
      vecs_a[1] = '{1'b1, 1'b1, 16'h6AB3, 16'h0000, 16'h0000};
      vecs_a[2] = '{1'b0, 1'b1, 16'h6AB3, 16'h0000, 16'h6AB3};
      vecs_a[3] = '{1'b0, 1'b0, 16'h0800, 16'h6AB3, 16'h6AB3};
      vecs_a[4] = '{1'b0, 1'b0, 16'h0800, 16'h6AB3, 16'h6AB3};
      vecs_a[5] = '{1'b0, 1'b0, 16'h0800, 16'h6AB3, 16'h6AB3};
      vecs_a[6] = '{1'b0, 1'b1, 16'h0F00, 16'h6AB3, 16'h0F00};
      // Back-to-back writes, same-value reload, then hold.
      vecs_b[0] = '{1'b0, 1'b1, 16'h1234, 16'hFFFF, 16'h1234};
      vecs_b[1] = '{1'b0, 1'b1, 16'hABCD, 16'h1234, 16'hABCD};
      vecs_b[2] = '{1'b0, 1'b1, 16'hABCD, 16'hABCD, 16'hABCD};
      vecs_b[3] = '{1'b0, 1'b1, 16'h8001, 16'hABCD, 16'h8001};
      vecs_b[4] = '{1'b0, 1'b0, 16'h0000, 16'h8001, 16'h8001};

      RESET = 1'b1;
      w     = 1'b1;
      in    = 16'h6AB3;
      #1;
      check("powerup_no_clock", out, 16'h0000);

      for (int i = 0; i < 7; i++) apply(vecs_a[i], "a", i);

      // out = 0x0F00, w = 1: change in between edges, then async reset mid-cycle.
      @(negedge CLK);
      in = 16'hFFFF;
      #1;
      check("in_change_between_edges", out, 16'h0F00);
      #1;
      RESET = 1'b1;
      #1;
      check("async_reset_mid_cycle", out, 16'h0000);
      @(posedge CLK);
      #1;
      check("reset_held_over_edge", out, 16'h0000);

      // Release with w = 0: stays cleared, then full-width write.
      @(negedge CLK);
      RESET = 1'b0;
      w     = 1'b0;
      @(posedge CLK);
      #1;
      check("release_w0_holds_zero", out, 16'h0000);
      @(negedge CLK);
      w  = 1'b1;
      in = 16'hFFFF;
      #1;
      check("full_width_before_edge", out, 16'h0000);
      @(posedge CLK);
      #1;
      check("full_width_after_edge", out, 16'hFFFF);

      for (int i = 0; i < 5; i++) apply(vecs_b[i], "b", i);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
